// File: rtl/fd_pkg.sv
// Shared types and constants for the fetch/decode queue.
package fd_pkg;

    // Field width of the reference entry layout (RV32).
    localparam int unsigned FD_DATA_WIDTH = 32;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    // One queued fetch result; field order is also the packing order in storage.
    typedef struct packed {
        logic [FD_DATA_WIDTH-1:0] instr;
        logic [FD_DATA_WIDTH-1:0] pc;
        logic [FD_DATA_WIDTH-1:0] pc_plus4;
    } fd_entry_t;

    localparam int unsigned FD_ENTRY_WIDTH = $bits(fd_entry_t);

endpackage

// File: rtl/fd_queue_mem.sv
// Register-array storage for the fetch/decode queue: one synchronous write port,
// one asynchronous read port. Contents are never cleared; the owner masks stale data.
module fd_queue_mem #(
    parameter int unsigned WIDTH = 96,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the addressed entry on a clock edge when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_decode_queue.sv
// Fetch->Decode pipeline queue: DEPTH-entry circular buffer with valid/ready on both
// sides, flush, and a NOP bubble presented whenever no entry is held.
module fetch_decode_queue
    import fd_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           DEPTH      = 2,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(NOP_INSTR_DEFAULT)
) (
    input  logic                       clk,
    input  logic                       rst,
    // Fetch side
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_WIDTH-1:0]      instr_f,
    input  logic [DATA_WIDTH-1:0]      pc_f,
    input  logic [DATA_WIDTH-1:0]      pc_plus4_f,
    // Control
    input  logic                       flush,
    // Decode side
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [DATA_WIDTH-1:0]      instr_d,
    output logic [DATA_WIDTH-1:0]      pc_d,
    output logic [DATA_WIDTH-1:0]      pc_plus4_d,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    // Same field order as fd_entry_t, scaled to DATA_WIDTH.
    localparam int unsigned ENTRY_W = 3 * DATA_WIDTH;

    // Pointer wrap relies on DEPTH being a power of two.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
        $error("fetch_decode_queue: DEPTH must be a power of two and at least 2");
    end

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               mem_we;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;

    // Status and handshake, all derived from registered occupancy only.
    always_comb begin
        full      = (cnt_q == CNT_W'(DEPTH));
        empty     = (cnt_q == '0);
        in_ready  = !full;
        out_valid = !empty;
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        // A push coinciding with flush is dropped, so don't touch storage either.
        mem_we    = push && !flush;
        wr_entry  = {instr_f, pc_f, pc_plus4_f};
    end

    fd_queue_mem #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_q),
        .rdata (rd_entry)
    );

    // Next-state for pointers and occupancy; flush overrides push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Pointer and occupancy registers; reset empties the queue immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Head presentation: NOP bubble when empty hides whatever stale data storage holds.
    always_comb begin
        instr_d    = NOP_INSTR;
        pc_d       = '0;
        pc_plus4_d = '0;
        if (!empty) begin
            instr_d    = rd_entry[3*DATA_WIDTH-1:2*DATA_WIDTH];
            pc_d       = rd_entry[2*DATA_WIDTH-1:DATA_WIDTH];
            pc_plus4_d = rd_entry[DATA_WIDTH-1:0];
        end
    end

    assign count = cnt_q;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Self-checking bench for fetch_decode_queue against a queue-based reference model.
module tb_fetch_decode_queue;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] instr_f;
    logic [DW-1:0] pc_f;
    logic [DW-1:0] pc_plus4_f;
    logic          flush;
    logic          out_ready;
    logic          out_valid;
    logic [DW-1:0] instr_d;
    logic [DW-1:0] pc_d;
    logic [DW-1:0] pc_plus4_d;
    logic [CW-1:0] count;

    ent_t        model[$];
    logic [31:0] popped[$];
    int          passed = 0;
    int          total  = 0;

    always #5 clk = ~clk;

    fetch_decode_queue #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr_f    (instr_f),
        .pc_f       (pc_f),
        .pc_plus4_f (pc_plus4_f),
        .flush      (flush),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .instr_d    (instr_d),
        .pc_d       (pc_d),
        .pc_plus4_d (pc_plus4_d),
        .count      (count)
    );

    function automatic bit model_accepts();
        return in_valid && (model.size() < DEPTH);
    endfunction

    function automatic logic [CW-1:0] exp_count();
        return CW'(model.size());
    endfunction

    function automatic logic [3*DW+CW+1:0] exp_vector();
        ent_t h;
        if (model.size() == 0) begin
            h = '{NOP, 32'h0, 32'h0};
        end else begin
            h = model[0];
        end
        return {model.size() != 0, model.size() < DEPTH, exp_count(), h.instr, h.pc, h.pc4};
    endfunction

    // Advance one clock: model applies the queue rules to the inputs held this cycle.
    task automatic step();
        bit   do_push;
        bit   do_pop;
        ent_t e;
        do_push = model_accepts();
        do_pop  = (model.size() > 0) && out_ready;
        e       = '{instr_f, pc_f, pc_plus4_f};
        @(posedge clk);
        if (flush) begin
            model.delete();
        end else begin
            if (do_pop) begin
                popped.push_back(model[0].pc);
                void'(model.pop_front());
            end
            if (do_push) model.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic set_entry(input logic [31:0] instr, input logic [31:0] pc);
        instr_f    = instr;
        pc_f       = pc;
        pc_plus4_f = pc + 32'd4;
    endtask

    task automatic empty_queue();
        in_valid = 1'b0;
        flush    = 1'b1;
        step();
        flush = 1'b0;
        popped.delete();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_entry(32'h0050_0093, 32'h0);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid);
        else passed++;
        total++;
        if (instr_d !== NOP) $display("FAIL reset_instr_d got=%h want=%h", instr_d, NOP);
        else passed++;
        total++;
        if (count !== '0) $display("FAIL reset_count got=%0d want=0", count);
        else passed++;
        total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", in_ready);
        else passed++;
        total++;
        if ({pc_d, pc_plus4_d} !== 64'h0) $display("FAIL reset_pc got=%h/%h want=0/0", pc_d, pc_plus4_d);
        else passed++;
        rst = 1'b0;
        model.delete();
        step();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1) $display("FAIL first_push_valid got=%b want=1", out_valid);
        else passed++;
        total++;
        if ({instr_d, pc_d} !== {32'h0050_0093, 32'h0})
            $display("FAIL first_push_data got=%h/%h want=00500093/00000000", instr_d, pc_d);
        else passed++;
        total++;
        if (count !== CW'(1)) $display("FAIL first_push_count got=%0d want=1", count);
        else passed++;
    endtask

    task automatic test_stall_fill();
        int nf = 0;
        empty_queue();
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            set_entry(32'h1000_0000 + nf, nf * 4);
            if (model_accepts()) begin
                step();
                nf++;
            end else begin
                step();
            end
        end
        total++;
        if (count !== CW'(2) || in_ready !== 1'b0)
            $display("FAIL stall_full got count=%0d ready=%b want count=2 ready=0", count, in_ready);
        else passed++;
        total++;
        if (pc_d !== 32'h0) $display("FAIL stall_head got=%h want=0", pc_d);
        else passed++;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && (nf < 3 || model.size() > 0); c++) begin
            in_valid = (nf < 3);
            set_entry(32'h1000_0000 + nf, nf * 4);
            if (model_accepts()) begin
                step();
                nf++;
            end else begin
                step();
            end
        end
        in_valid = 1'b0;
        total++;
        if (popped.size() != 3) $display("FAIL stall_pop_count got=%0d want=3", popped.size());
        else passed++;
        for (int i = 0; i < 3 && i < popped.size(); i++) begin
            total++;
            if (popped[i] !== i * 4) $display("FAIL stall_order[%0d] got=%h want=%h", i, popped[i], i * 4);
            else passed++;
        end
        total++;
        if (out_valid !== 1'b0 || count !== '0)
            $display("FAIL stall_drained got valid=%b count=%0d want 0/0", out_valid, count);
        else passed++;
    endtask

    task automatic test_streaming();
        int nf = 0;
        empty_queue();
        out_ready = 1'b1;
        for (int c = 0; c < 40 && (nf < 10 || model.size() > 0); c++) begin
            in_valid = (nf < 10);
            set_entry(32'h2000_0000 + nf, nf * 4);
            if (c >= 1 && c <= 10) begin
                total++;
                if (count !== CW'(1)) $display("FAIL stream_count c=%0d got=%0d want=1", c, count);
                else passed++;
            end
            total++;
            if (pc_d !== exp_vector()[DW*2-1:DW])
                $display("FAIL stream_head c=%0d got=%h want=%h", c, pc_d, exp_vector()[DW*2-1:DW]);
            else passed++;
            if (model_accepts()) begin
                step();
                nf++;
            end else begin
                step();
            end
        end
        in_valid = 1'b0;
        total++;
        if (popped.size() != 10) $display("FAIL stream_pop_count got=%0d want=10", popped.size());
        else passed++;
        for (int i = 0; i < 10 && i < popped.size(); i++) begin
            total++;
            if (popped[i] !== i * 4) $display("FAIL stream_order[%0d] got=%h want=%h", i, popped[i], i * 4);
            else passed++;
        end
    endtask

    task automatic test_flush();
        for (int k = 1; k <= 2; k++) begin
            empty_queue();
            out_ready = 1'b0;
            in_valid  = 1'b1;
            for (int i = 0; i < k; i++) begin
                set_entry(32'h3000_0000 + i, 32'h300 + i * 4);
                step();
            end
            set_entry(32'h3BAD_0000, 32'h3BC);
            flush = 1'b1;
            step();
            flush    = 1'b0;
            in_valid = 1'b0;
            total++;
            if ({out_valid, count, instr_d, pc_d} !== {1'b0, CW'(0), NOP, 32'h0})
                $display("FAIL flush_k%0d got valid=%b count=%0d instr=%h pc=%h want 0/0/%h/0",
                         k, out_valid, count, instr_d, pc_d, NOP);
            else passed++;
            out_ready = 1'b1;
            step();
            total++;
            if (out_valid !== 1'b0 || pc_d === 32'h3BC)
                $display("FAIL flush_dropped_k%0d got valid=%b pc=%h want valid=0", k, out_valid, pc_d);
            else passed++;
        end
    endtask

    task automatic test_push_pop();
        empty_queue();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_entry(32'h4000_0000, 32'h100);
        step();
        set_entry(32'h4000_0001, 32'h104);
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        total++;
        if (count !== CW'(1)) $display("FAIL pushpop_count got=%0d want=1", count);
        else passed++;
        total++;
        if ({instr_d, pc_d, pc_plus4_d} !== {32'h4000_0001, 32'h104, 32'h108})
            $display("FAIL pushpop_head got=%h/%h/%h want=40000001/00000104/00000108",
                     instr_d, pc_d, pc_plus4_d);
        else passed++;
    endtask

    task automatic test_async_reset();
        empty_queue();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_entry(32'h5000_0000, 32'h500);
        step();
        set_entry(32'h5000_0001, 32'h504);
        step();
        in_valid = 1'b0;
        total++;
        if (count !== CW'(2)) $display("FAIL areset_precount got=%0d want=2", count);
        else passed++;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({out_valid, in_ready, count, instr_d, pc_d, pc_plus4_d} !==
            {1'b0, 1'b1, CW'(0), NOP, 32'h0, 32'h0})
            $display("FAIL areset_async got valid=%b ready=%b count=%0d instr=%h pc=%h pc4=%h",
                     out_valid, in_ready, count, instr_d, pc_d, pc_plus4_d);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        model.delete();
    endtask

    task automatic test_random();
        logic [3*DW+CW+1:0] obs;
        logic [3*DW+CW+1:0] exp;
        empty_queue();
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            instr_f    = $urandom;
            pc_f       = $urandom;
            pc_plus4_f = pc_f + 32'd4;
            obs = {out_valid, in_ready, count, instr_d, pc_d, pc_plus4_d};
            exp = exp_vector();
            total++;
            if (obs !== exp) $display("FAIL random c=%0d got=%h want=%h", c, obs, exp);
            else passed++;
            step();
        end
        flush    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stall_fill();
        test_streaming();
        test_flush();
        test_push_pop();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
